// File: rtl/inorder_multi_ch_scoreboard.sv
// ---------------------------------------------------------------------------
// inorder_multi_ch_scoreboard
//
// Multi-channel in-order data scoreboard. It shadows a DUT FIFO (or a bank of
// FIFOs) from the DUT's accepted-write / accepted-read strobes. Each read word
// is checked against the oldest pending write on the same channel. The block
// only observes the DUT and drives none of its signals.
//
// Parameters
//   DATA_W  compared data width
//   DEPTH   max pending words per channel (power of 2, >= 2)
//   NUM_CH  number of independent in-order channels (>= 1)
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_vld/in_ch/in_data  accepted write: strobe, channel, data
//   out_vld/out_ch/out_data accepted read: strobe, channel, data
//   err_clr               synchronous clear of the sticky errors
//   ch_empty              bit i set when channel i has no pending words
//   total_pend            pending words summed over all channels
//   mismatch_p            one-cycle pulse, the cycle after a failed compare
//   err_mismatch/err_overflow/err_underflow  sticky error flags
//   sb_state              0 IDLE, 1 BUSY, 2 FAIL
//
// Optional feature (macro SB_FIRST_ERR_CAPTURE_EN)
//   Adds fe_vld, fe_ch, fe_exp, fe_act: channel, expected and actual data of
//   the first mismatch since reset or err_clr. Later mismatches do not
//   overwrite it; it clears together with the sticky errors.
// ---------------------------------------------------------------------------
module inorder_multi_ch_scoreboard #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int NUM_CH = 2,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_vld,
    input  logic [CH_W-1:0]         in_ch,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    out_vld,
    input  logic [CH_W-1:0]         out_ch,
    input  logic [DATA_W-1:0]       out_data,
    input  logic                    err_clr,
    output logic [NUM_CH-1:0]       ch_empty,
    output logic [CNT_W+CH_W-1:0]   total_pend,
    output logic                    mismatch_p,
    output logic                    err_mismatch,
    output logic                    err_overflow,
    output logic                    err_underflow,
    output logic [1:0]              sb_state
`ifdef SB_FIRST_ERR_CAPTURE_EN
    ,
    output logic                    fe_vld,
    output logic [CH_W-1:0]         fe_ch,
    output logic [DATA_W-1:0]       fe_exp,
    output logic [DATA_W-1:0]       fe_act
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int TP_W  = CNT_W + CH_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
    localparam logic [CH_W:0]    NUM_CH_L = (CH_W + 1)'(NUM_CH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    logic [DATA_W-1:0] mem_r    [NUM_CH][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr_r [NUM_CH];
    logic [CNT_W-1:0]  cnt_r    [NUM_CH];
    logic [CNT_W-1:0]  cnt_nxt_s[NUM_CH];
    state_t            state_r;

    logic              in_ok_s;
    logic              out_ok_s;
    logic              same_ch_s;
    logic [CNT_W-1:0]  cnt_in_s;
    logic [CNT_W-1:0]  cnt_out_s;
    logic [DATA_W-1:0] rd_word_s;
    logic [DATA_W-1:0] exp_s;
    logic              bypass_s;
    logic              push_do_s;
    logic              pop_do_s;
    logic              mismatch_s;
    logic              overflow_s;
    logic              underflow_s;
    logic              any_err_s;
    logic [NUM_CH-1:0] push_hit_s;
    logic [NUM_CH-1:0] pop_hit_s;
    logic [TP_W-1:0]   total_nxt_s;

    // Classify this cycle's strobes: bypass, real push/pop, compare and error events.
    always_comb begin
        // Channel ids beyond NUM_CH-1 are ignored rather than aliased.
        in_ok_s   = in_vld  && ({1'b0, in_ch}  < NUM_CH_L);
        out_ok_s  = out_vld && ({1'b0, out_ch} < NUM_CH_L);
        same_ch_s = in_ok_s && out_ok_s && (in_ch == out_ch);
        cnt_in_s  = in_ok_s  ? cnt_r[in_ch]  : ZERO_CNT;
        cnt_out_s = out_ok_s ? cnt_r[out_ch] : ZERO_CNT;
        rd_word_s = out_ok_s ? mem_r[out_ch][rd_ptr_r[out_ch]] : {DATA_W{1'b0}};

        // Empty channel written and read in the same cycle: the word falls through.
        bypass_s  = same_ch_s && (cnt_out_s == ZERO_CNT);
        pop_do_s  = out_ok_s && (cnt_out_s != ZERO_CNT);
        // At full, a same-channel pop frees the slot the push lands in.
        push_do_s = in_ok_s && !bypass_s && ((cnt_in_s != FULL_CNT) || same_ch_s);

        exp_s       = bypass_s ? in_data : rd_word_s;
        mismatch_s  = (bypass_s || pop_do_s) && (out_data != exp_s);
        overflow_s  = in_ok_s  && (cnt_in_s  == FULL_CNT) && !same_ch_s;
        underflow_s = out_ok_s && (cnt_out_s == ZERO_CNT) && !same_ch_s;
        any_err_s   = mismatch_s || overflow_s || underflow_s;
    end

    // Next per-channel occupancy and the total across channels.
    always_comb begin
        total_nxt_s = {TP_W{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            push_hit_s[i] = push_do_s && (in_ch  == CH_W'(i));
            pop_hit_s[i]  = pop_do_s  && (out_ch == CH_W'(i));
            case ({push_hit_s[i], pop_hit_s[i]})
                2'b10:   cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
                2'b01:   cnt_nxt_s[i] = cnt_r[i] - CNT_W'(1);
                default: cnt_nxt_s[i] = cnt_r[i];
            endcase
            total_nxt_s = total_nxt_s + TP_W'(cnt_nxt_s[i]);
        end
    end

    // Payload storage; stale words are unreachable once the pointers reset.
    always_ff @(posedge clk) begin
        if (push_do_s) begin
            mem_r[in_ch][wr_ptr_r[in_ch]] <= in_data;
        end
    end

    // Pointers, counts, registered status, sticky errors and the status FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr_r[i] <= {PTR_W{1'b0}};
                rd_ptr_r[i] <= {PTR_W{1'b0}};
                cnt_r[i]    <= ZERO_CNT;
            end
            ch_empty      <= {NUM_CH{1'b1}};
            total_pend    <= {TP_W{1'b0}};
            mismatch_p    <= 1'b0;
            err_mismatch  <= 1'b0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            state_r       <= ST_IDLE;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_r[i]    <= cnt_nxt_s[i];
                ch_empty[i] <= (cnt_nxt_s[i] == ZERO_CNT);
                if (push_hit_s[i]) wr_ptr_r[i] <= wr_ptr_r[i] + PTR_W'(1);
                if (pop_hit_s[i])  rd_ptr_r[i] <= rd_ptr_r[i] + PTR_W'(1);
            end
            total_pend <= total_nxt_s;
            mismatch_p <= mismatch_s;
            // A new error in the clearing cycle keeps its flag set.
            err_mismatch  <= mismatch_s  || (err_mismatch  && !err_clr);
            err_overflow  <= overflow_s  || (err_overflow  && !err_clr);
            err_underflow <= underflow_s || (err_underflow && !err_clr);

            if (any_err_s) begin
                state_r <= ST_FAIL;
            end else begin
                case (state_r)
                    ST_IDLE, ST_BUSY: begin
                        state_r <= (total_nxt_s != {TP_W{1'b0}}) ? ST_BUSY : ST_IDLE;
                    end
                    ST_FAIL: begin
                        if (err_clr) begin
                            state_r <= (total_nxt_s != {TP_W{1'b0}}) ? ST_BUSY : ST_IDLE;
                        end
                    end
                    default: state_r <= ST_IDLE;
                endcase
            end
        end
    end

    assign sb_state = state_r;

`ifdef SB_FIRST_ERR_CAPTURE_EN
    // First-mismatch capture; a clear and a mismatch together restart the capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            fe_vld <= 1'b0;
            fe_ch  <= {CH_W{1'b0}};
            fe_exp <= {DATA_W{1'b0}};
            fe_act <= {DATA_W{1'b0}};
        end else if (mismatch_s && (!fe_vld || err_clr)) begin
            fe_vld <= 1'b1;
            fe_ch  <= out_ch;
            fe_exp <= exp_s;
            fe_act <= out_data;
        end else if (err_clr) begin
            fe_vld <= 1'b0;
            fe_ch  <= {CH_W{1'b0}};
            fe_exp <= {DATA_W{1'b0}};
            fe_act <= {DATA_W{1'b0}};
        end
    end
`endif

endmodule
